// File: rtl/gated_bus_arbiter.sv
// Two-requester round-robin arbiter for the gated LED bus: registered grants,
// per-grant hold limit with a timeout pulse, and a one-cycle dead gap between owners.
module gated_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] dat0,
    input  logic [1:0] dat1,
    input  logic       done0,
    input  logic       done1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic [1:0] bus,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_reg, state_next;
    logic       last_reg, last_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       timeout_reg, timeout_next;
    logic       owner_req, owner_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Only the current owner's request/done matter; the other side waits for GAP/IDLE.
    assign owner_req  = (state_reg == OWN1) ? req1  : req0;
    assign owner_done = (state_reg == OWN1) ? done1 : done0;

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE, GAP: begin
                state_next = IDLE;
                // On a tie the requester that was not granted last wins.
                if (req0 && (!req1 || last_reg)) begin
                    state_next    = OWN0;
                    last_next     = 1'b0;
                    hold_cnt_next = 8'd1;
                end else if (req1) begin
                    state_next    = OWN1;
                    last_next     = 1'b1;
                    hold_cnt_next = 8'd1;
                end
            end
            OWN0, OWN1: begin
                if (owner_done || !owner_req) begin
                    state_next = GAP;
                end else if ((MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT)) begin
                    state_next   = GAP;
                    timeout_next = 1'b1;
                end else if (hold_cnt_reg != 8'hff) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt0    = (state_reg == OWN0);
    assign gnt1    = (state_reg == OWN1);
    assign sel     = gnt0 | gnt1;
    assign bus     = gnt0 ? dat0 : (gnt1 ? dat1 : 2'b00);
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_gated_bus_arbiter.sv
// Scoreboard bench for gated_bus_arbiter: three instances (hold limits 15, 4, unlimited)
// share randomized stimulus and are checked against an ownership-level reference model.
module tb_gated_bus_arbiter;

    localparam int LIM [3] = '{15, 4, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
    logic [1:0] dat0 = 2'b00, dat1 = 2'b00;

    logic       gnt0_w [3];
    logic       gnt1_w [3];
    logic       sel_w [3];
    logic       timeout_w [3];
    logic [1:0] bus_w [3];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            gated_bus_arbiter #(.MAX_HOLD(LIM[gi])) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .req0    (req0),
                .req1    (req1),
                .dat0    (dat0),
                .dat1    (dat1),
                .done0   (done0),
                .done1   (done1),
                .gnt0    (gnt0_w[gi]),
                .gnt1    (gnt1_w[gi]),
                .sel     (sel_w[gi]),
                .bus     (bus_w[gi]),
                .timeout (timeout_w[gi])
            );
        end
    endgenerate

    // Reference model: who owns the bus, how long they have held it, who went last.
    int   owner [3] = '{-1, -1, -1};
    int   held  [3] = '{0, 0, 0};
    int   last  [3] = '{1, 1, 1};
    bit   tmo   [3] = '{0, 0, 0};
    logic [8:0] exp_q [$];
    int   checks = 0;
    int   failures = 0;

    task automatic model_step();
        logic [8:0] e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            tmo[i] = 1'b0;
            if (!rst_n) begin
                owner[i] = -1;
                held[i]  = 0;
                last[i]  = 1;
            end else if (owner[i] >= 0) begin
                if ((owner[i] == 0 && (done0 || !req0)) || (owner[i] == 1 && (done1 || !req1))) begin
                    owner[i] = -1;
                end else if (LIM[i] != 0 && held[i] == LIM[i]) begin
                    owner[i] = -1;
                    tmo[i]   = 1'b1;
                end else begin
                    held[i] = held[i] + 1;
                end
            end else begin
                if (req0 && req1) owner[i] = 1 - last[i];
                else if (req0)    owner[i] = 0;
                else if (req1)    owner[i] = 1;
                if (owner[i] >= 0) begin
                    last[i] = owner[i];
                    held[i] = 1;
                end
            end
            e[3*i +: 3] = {tmo[i], (owner[i] == 0) ? 2'd1 : ((owner[i] == 1) ? 2'd2 : 2'd0)};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({gnt0_w[i], gnt1_w[i], sel_w[i], bus_w[i], timeout_w[i]} !== 6'b0) begin
                failures++;
                $display("FAIL async_reset dut%0d got gnt0/gnt1/sel/bus/timeout=%b expected 000000",
                         i, {gnt0_w[i], gnt1_w[i], sel_w[i], bus_w[i], timeout_w[i]});
            end
        end
    endtask

    task automatic rand_dat();
        dat0 = 2'($urandom);
        dat1 = 2'($urandom);
    endtask

    // Monitor: every output cycle is compared with the next expected entry.
    logic [8:0] mon_e;
    logic [1:0] mon_own;
    logic [1:0] mon_bus;
    logic [5:0] mon_exp, mon_act;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    mon_own = mon_e[3*i +: 2];
                    mon_bus = (mon_own == 2'd1) ? dat0 : ((mon_own == 2'd2) ? dat1 : 2'b00);
                    mon_exp = {mon_own == 2'd1, mon_own == 2'd2, mon_own != 2'd0, mon_bus, mon_e[3*i+2]};
                    mon_act = {gnt0_w[i], gnt1_w[i], sel_w[i], bus_w[i], timeout_w[i]};
                    checks++;
                    if (mon_act !== mon_exp) begin
                        failures++;
                        $display("FAIL cycle_outputs dut%0d t=%0t got gnt0/gnt1/sel/bus/timeout=%b expected %b",
                                 i, $time, mon_act, mon_exp);
                    end
                end
                $display("txn t=%0t req=%b%b done=%b%b exp=%b", $time, req1, req0, done1, done0, mon_e);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset();
        repeat (2) cyc();
        rst_n = 1'b1;

        // Single owner, done in the 4th grant cycle.
        dat0 = 2'b10;
        req0 = 1'b1;
        repeat (4) cyc();
        done0 = 1'b1;
        cyc();
        done0 = 1'b0;
        req0  = 1'b0;
        repeat (3) cyc();

        // Alternation: both requesting, each releases after 3 cycles.
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (40) begin
            cyc();
            done0 = (owner[0] == 0 && held[0] == 3);
            done1 = (owner[0] == 1 && held[0] == 3);
            rand_dat();
        end
        {req0, req1, done0, done1} = 4'b0;
        repeat (2) cyc();

        // Hold limit alone, then with contention.
        req1 = 1'b1;
        repeat (40) begin cyc(); rand_dat(); end
        req0 = 1'b1;
        repeat (40) begin cyc(); rand_dat(); end
        {req0, req1} = 2'b0;
        repeat (2) cyc();

        // done coincides with the 4-cycle limit.
        req0 = 1'b1;
        repeat (30) begin
            cyc();
            done0 = (owner[1] == 0 && held[1] == 4);
        end
        {req0, done0} = 2'b0;
        repeat (2) cyc();

        // Reset mid-OWN1, then a tie must go to requester 0.
        dat1 = 2'b11;
        req1 = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset();
        req0 = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        {req0, req1} = 2'b0;
        repeat (2) cyc();

        // Random traffic.
        repeat (400) begin
            cyc();
            req0  = ($urandom_range(0, 9) < 7);
            req1  = ($urandom_range(0, 9) < 7);
            done0 = ($urandom_range(0, 9) < 2);
            done1 = ($urandom_range(0, 9) < 2);
            rand_dat();
        end
        {req0, req1, done0, done1} = 4'b0;
        repeat (2) cyc();

        // Long single hold: the unlimited instance never times out.
        req0 = 1'b1;
        repeat (300) cyc();
        req0 = 1'b0;
        repeat (3) cyc();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
